// File: rtl/ring_freq_meter.sv
// Ring-oscillator frequency meter: synchronises osc_in, counts its rising edges
// over a fixed window of clk cycles and publishes a held result with a valid pulse.
module ring_freq_meter #(
    parameter int unsigned GATE_CYCLES = 1024,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             enable,
    input  logic             start,
    input  logic             continuous,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    localparam int unsigned SETTLE_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned TMR_MAX       = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TMR_W         = $clog2(TMR_MAX);
    localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       acc_q;
    logic                   sat_q;
    logic [TMR_W-1:0]       tmr_q;
    logic                   sync_s_c;
    logic                   rise_c;

    assign sync_s_c = sync_q[SYNC_STAGES-1];
    assign rise_c   = sync_s_c & ~prev_q;

    // busy stays high through the cycle in which the result is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            tmr_q     <= '0;
            count_out <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q <= sync_s_c;
            valid  <= 1'b0;

            case (state_q)
                IDLE: begin
                    busy <= enable & start;
                    if (enable && start) begin
                        state_q <= SETTLE;
                        tmr_q   <= TMR_W'(SETTLE_CYCLES - 1);
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                    end
                end

                // stale synchroniser contents are flushed here without counting
                SETTLE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else if (tmr_q == '0) begin
                        state_q <= GATE;
                        tmr_q   <= TMR_W'(GATE_CYCLES - 1);
                    end else begin
                        tmr_q <= tmr_q - TMR_W'(1);
                    end
                end

                GATE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        if (rise_c) begin
                            if (acc_q == ACC_MAX) begin
                                sat_q <= 1'b1;
                            end else begin
                                acc_q <= acc_q + CNT_W'(1);
                            end
                        end
                        if (tmr_q == '0) begin
                            state_q <= DONE;
                        end else begin
                            tmr_q <= tmr_q - TMR_W'(1);
                        end
                    end
                end

                // result is always published, even if enable falls this cycle
                DONE: begin
                    count_out <= acc_q;
                    overflow  <= sat_q;
                    valid     <= 1'b1;
                    if (enable && continuous) begin
                        state_q <= GATE;
                        tmr_q   <= TMR_W'(GATE_CYCLES - 1);
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Self-checking bench for ring_freq_meter: two widths share one stimulus stream and
// are compared every cycle against a window/schedule-level reference model.
module tb_ring_freq_meter;

    localparam int unsigned G    = 64;
    localparam int unsigned S    = 2;
    localparam int unsigned MAXE = 16384;

    logic        clk;
    logic        rst, osc_in, enable, start, continuous;
    logic [15:0] cnt16;
    logic        v16, b16, o16;
    logic [3:0]  cnt4;
    logic        v4, b4, o4;

    ring_freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(S)) u_w16 (
        .clk(clk), .rst(rst), .osc_in(osc_in), .enable(enable), .start(start),
        .continuous(continuous), .count_out(cnt16), .valid(v16), .busy(b16), .overflow(o16)
    );

    ring_freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S)) u_w4 (
        .clk(clk), .rst(rst), .osc_in(osc_in), .enable(enable), .start(start),
        .continuous(continuous), .count_out(cnt4), .valid(v4), .busy(b4), .overflow(o4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;
    bit osc_hist [0:MAXE-1];

    // oscillator source: 0 constant, 1 periodic, 2 random, 3 step to 1 at a given edge
    int osc_mode = 0, osc_lvl = 0, osc_per = 4, osc_ph = 0, osc_step = 0;

    // reference model state
    bit m_active = 0;
    int m_lo, m_hi, m_pub;
    int e_cnt16 = 0, e_ovf16 = 0, e_cnt4 = 0, e_ovf4 = 0, e_valid = 0, e_busy = 0;
    bit lat_armed = 0;
    int lat_start = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_cnt + 1, got, exp);
        end
    endtask

    function automatic bit osc_val(input int k);
        case (osc_mode)
            0:       return osc_lvl != 0;
            1:       return ((k + osc_ph) % osc_per) < (osc_per / 2);
            2:       return $urandom_range(0, 1) != 0;
            default: return k >= osc_step;
        endcase
    endfunction

    // number of 0->1 transitions between consecutive clk samples of osc_in with the later sample in [lo,hi]
    function automatic int rises(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++)
            if (osc_hist[i] && !osc_hist[i-1]) n++;
        return n;
    endfunction

    // expected outputs just after clk edge k, given the inputs sampled at that edge
    task automatic model_step(input int k);
        int n;
        e_valid = 0;
        if (rst) begin
            m_active = 0;
            e_cnt16 = 0; e_ovf16 = 0; e_cnt4 = 0; e_ovf4 = 0; e_busy = 0;
        end else if (!m_active) begin
            if (enable && start) begin
                m_active  = 1;
                m_lo      = k + 2;
                m_hi      = k + G + 1;
                m_pub     = k + S + G + 2;
                lat_armed = 1;
                lat_start = k;
            end
            e_busy = m_active;
        end else if (k == m_pub) begin
            n       = rises(m_lo, m_hi);
            e_cnt16 = (n > 65535) ? 65535 : n;
            e_ovf16 = (n > 65535) ? 1 : 0;
            e_cnt4  = (n > 15) ? 15 : n;
            e_ovf4  = (n > 15) ? 1 : 0;
            e_valid = 1;
            e_busy  = 1;
            if (enable && continuous) begin
                m_lo  = k - S + 1;
                m_hi  = k + G - S;
                m_pub = k + G + 1;
            end else begin
                m_active = 0;
            end
        end else if (!enable) begin
            m_active = 0;
            e_busy   = 0;
        end else begin
            e_busy = 1;
        end
    endtask

    task automatic step();
        int k;
        k = edge_cnt + 1;
        if (k >= MAXE) begin
            $display("FAIL edge_budget: got %0d expected <%0d", k, MAXE);
            n_err++;
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "edge budget exhausted");
        end
        osc_in = osc_val(k);
        osc_hist[k] = osc_in;
        model_step(k);
        @(posedge clk);
        #1;
        check_eq("valid16", 32'(v16), 32'(e_valid));
        check_eq("valid4",  32'(v4),  32'(e_valid));
        check_eq("busy16",  32'(b16), 32'(e_busy));
        check_eq("busy4",   32'(b4),  32'(e_busy));
        check_eq("count16", 32'(cnt16), 32'(e_cnt16));
        check_eq("count4",  32'(cnt4),  32'(e_cnt4));
        check_eq("ovf16",   32'(o16), 32'(e_ovf16));
        check_eq("ovf4",    32'(o4),  32'(e_ovf4));
        if (lat_armed && v16) begin
            check_eq("latency", 32'(k - lat_start), 32'(S + G + 2));
            lat_armed = 0;
        end
        edge_cnt = k;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_periodic(input int per);
        osc_mode = 1;
        osc_per  = per;
        osc_ph   = 0;
    endtask

    initial begin
        rst = 1'b1; osc_in = 1'b0; enable = 1'b1; start = 1'b0; continuous = 1'b0;
        @(negedge clk);
        run(3);
        rst = 1'b0;
        run(3);

        // basic single measurement, then a slower oscillator
        set_periodic(4);
        pulse_start();
        run(80);
        set_periodic(16);
        pulse_start();
        run(80);

        // reset in the middle of a window with a held result
        set_periodic(4);
        pulse_start();
        run(75);
        pulse_start();
        run(30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(5);

        // continuous mode, dropped mid-window
        set_periodic(8);
        continuous = 1'b1;
        pulse_start();
        run(68 + 3 * 65);
        continuous = 1'b0;
        run(30);
        run(60);

        // one-cycle abort mid-window, then start pulses while busy
        set_periodic(4);
        pulse_start();
        run(30);
        enable = 1'b0;
        step();
        enable = 1'b1;
        run(10);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            run(9);
            pulse_start();
        end
        run(40);

        // static oscillator levels and an edge landing only in the settle phase
        osc_mode = 0; osc_lvl = 1;
        pulse_start();
        run(75);
        osc_lvl = 0;
        pulse_start();
        run(75);
        osc_mode = 3;
        osc_step = edge_cnt + 2;
        pulse_start();
        run(75);
        osc_mode = 0; osc_lvl = 0;
        run(5);

        // randomized traffic
        for (int blk = 0; blk < 16; blk++) begin
            osc_mode = $urandom_range(0, 2);
            osc_lvl  = $urandom_range(0, 1);
            osc_per  = 2 * $urandom_range(1, 10) + $urandom_range(0, 1);
            osc_ph   = $urandom_range(0, 31);
            for (int c = 0; c < 250; c++) begin
                enable     = ($urandom_range(0, 99) != 0);
                start      = ($urandom_range(0, 7) == 0);
                continuous = ($urandom_range(0, 2) == 0);
                rst        = ($urandom_range(0, 999) == 0);
                step();
            end
        end
        rst = 1'b0; start = 1'b0; continuous = 1'b0; enable = 1'b1;
        run(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
